// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit seven-segment display.
//   One shared segment bus is steered across four active-low digit anodes.
//   Each digit owns a SCAN_DIV-cycle slot.  The first BLANK_CYC cycles of
//   every slot are dark so that the previous digit's segments do not ghost
//   onto the next anode.  The BCD value is double-buffered: loads land in
//   a pending register and are copied to the display register only at a
//   frame boundary.
//
//   Optional build macro: LZ_BLANK_EN
//     When defined, leading zeros (digits 3..1) are blanked.  Digit 0 is
//     always shown.  Slot timing and frame_done are unaffected.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active-low
//   en          scan enable; low forces IDLE with blanked outputs
//   load        one-cycle pulse, samples bcd_in
//   bcd_in      {d3,d2,d1,d0}, 4 bits each, d0 in [3:0]
//   an          anode enables, active-low, an[i] = digit i
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   frame_done  one-cycle pulse after the last SHOW cycle of digit 3
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | scan stopped, pcnt=0, idx=0, outputs dark
// BLANK | dead-time at the start of a slot, outputs dark
// SHOW  | digit idx driven on the bus for the rest of the slot

module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 131072,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] bcd_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_LAST     = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   pending, display;
  logic          boundary;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          fd_nxt;
  logic [3:0]    digit;
  logic          dark;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;  // non-BCD codes show a dash
    endcase
    return s;
  endfunction

  always_comb begin
    digit = 4'd0;
    dark  = 1'b0;
    case (idx)
      2'd0: digit = display[3:0];
      2'd1: digit = display[7:4];
      2'd2: digit = display[11:8];
      2'd3: digit = display[15:12];
      default: digit = 4'd0;
    endcase
`ifdef LZ_BLANK_EN
    // A digit is a leading zero when it and every higher digit are zero.
    case (idx)
      2'd3: dark = (display[15:12] == 4'd0);
      2'd2: dark = (display[15:8] == 8'd0);
      2'd1: dark = (display[15:4] == 12'd0);
      default: dark = 1'b0;
    endcase
`else
    dark = 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    idx_nxt   = idx;
    boundary  = 1'b0;
    an_nxt    = 4'hF;
    seg_nxt   = 7'h7F;
    fd_nxt    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      pcnt_nxt  = '0;
      idx_nxt   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          pcnt_nxt  = '0;
          idx_nxt   = 2'd0;
          boundary  = 1'b1;
        end
        BLANK: begin
          pcnt_nxt = pcnt + PW'(1);
          if (pcnt == BLANK_LAST) state_nxt = SHOW;
        end
        SHOW: begin
          if (!dark) begin
            an_nxt  = ~(4'b0001 << idx);
            seg_nxt = seg_decode(digit);
          end
          if (pcnt == P_LAST) begin
            pcnt_nxt  = '0;
            idx_nxt   = idx + 2'd1;
            state_nxt = BLANK;
            if (idx == 2'd3) begin
              boundary = 1'b1;
              fd_nxt   = 1'b1;
            end
          end else begin
            pcnt_nxt = pcnt + PW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pcnt       <= '0;
      idx        <= 2'd0;
      pending    <= 16'h0000;
      display    <= 16'h0000;
      an         <= 4'hF;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      pcnt       <= pcnt_nxt;
      idx        <= idx_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= fd_nxt;
      if (load) pending <= bcd_in;
      // A load that coincides with the boundary bypasses pending.
      if (boundary) display <= load ? bcd_in : pending;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
//   Directed bench for seg7_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2.
//   Each 8-cycle slot shows 2 dark cycles followed by 6 lit cycles on the
//   pins; frame_done coincides with the last lit cycle of digit 3.

module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  seg7_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .bcd_in     (bcd_in),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

`ifdef LZ_BLANK_EN
  localparam logic [3:0] DARK_0042 = 4'b1100;
  localparam logic [3:0] DARK_0000 = 4'b1110;
`else
  localparam logic [3:0] DARK_0042 = 4'b0000;
  localparam logic [3:0] DARK_0000 = 4'b0000;
`endif

  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic check(input string tag, input logic [3:0] ae,
                       input logic [6:0] se, input logic fe);
    total++;
    assert (an === ae) else begin
      bad++;
      $error("FAIL %s an: got %h exp %h", tag, an, ae);
    end
    total++;
    assert (seg === se) else begin
      bad++;
      $error("FAIL %s seg: got %h exp %h", tag, seg, se);
    end
    total++;
    assert (frame_done === fe) else begin
      bad++;
      $error("FAIL %s frame_done: got %b exp %b", tag, frame_done, fe);
    end
  endtask

  // Runs n cycles of slot k; optionally pulses load on the slot's 8th edge.
  task automatic run_slot(input int k, input logic [6:0] se, input logic dark,
                          input logic ld_last, input logic [15:0] ld_val,
                          input int n);
    logic [3:0] ae;
    logic       fe;
    ae = ~(4'b0001 << k);
    for (int c = 1; c <= n; c++) begin
      if (ld_last && c == 8) begin
        load   = 1'b1;
        bcd_in = ld_val;
      end
      step();
      fe = (k == 3 && c == 8);
      if (c <= 2 || dark)
        check($sformatf("slot%0d_c%0d_dark", k, c), 4'hF, 7'h7F, fe);
      else
        check($sformatf("slot%0d_c%0d_lit", k, c), ae, se, fe);
    end
  endtask

  task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dark, input logic ld_last,
                           input logic [15:0] ld_val);
    run_slot(0, s0, dark[0], 1'b0, 16'h0, 8);
    run_slot(1, s1, dark[1], 1'b0, 16'h0, 8);
    run_slot(2, s2, dark[2], 1'b0, 16'h0, 8);
    run_slot(3, s3, dark[3], ld_last, ld_val, 8);
  endtask

  initial begin
    // Scenario 1: reset and idle
    rst_n  = 1'b0;
    en     = 1'b0;
    load   = 1'b0;
    bcd_in = 16'h0000;
    repeat (3) step();
    check("reset", 4'hF, 7'h7F, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      check("idle", 4'hF, 7'h7F, 1'b0);
    end

    // Scenario 2: load 1234 while idle, then scan two frames
    bcd_in = 16'h1234;
    load   = 1'b1;
    step();
    check("idle_load", 4'hF, 7'h7F, 1'b0);
    en = 1'b1;
    step();
    check("enable", 4'hF, 7'h7F, 1'b0);
    run_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 1'b0, 16'h0);
    run_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 1'b0, 16'h0);

    // Scenario 3: mid-frame load waits for the next frame
    run_slot(0, 7'h19, 1'b0, 1'b0, 16'h0, 8);
    run_slot(1, 7'h30, 1'b0, 1'b0, 16'h0, 8);
    load   = 1'b1;
    bcd_in = 16'h9876;
    run_slot(2, 7'h24, 1'b0, 1'b0, 16'h0, 8);
    run_slot(3, 7'h79, 1'b0, 1'b0, 16'h0, 8);
    // 9876 frame; pending gets 1111, then a boundary load of FA05 overrides it
    run_slot(0, 7'h02, 1'b0, 1'b0, 16'h0, 8);
    load   = 1'b1;
    bcd_in = 16'h1111;
    run_slot(1, 7'h78, 1'b0, 1'b0, 16'h0, 8);
    run_slot(2, 7'h00, 1'b0, 1'b0, 16'h0, 8);
    run_slot(3, 7'h10, 1'b0, 1'b1, 16'hFA05, 8);

    // Scenario 4: non-BCD digits show a dash
    run_frame(7'h12, 7'h40, 7'h3F, 7'h3F, 4'b0000, 1'b0, 16'h0);

    // Scenario 5a: drop en during the digit-2 SHOW slot
    run_slot(0, 7'h12, 1'b0, 1'b0, 16'h0, 8);
    run_slot(1, 7'h40, 1'b0, 1'b0, 16'h0, 8);
    run_slot(2, 7'h3F, 1'b0, 1'b0, 16'h0, 4);
    en = 1'b0;
    step();
    check("en_drop", 4'hF, 7'h7F, 1'b0);
    repeat (3) begin
      step();
      check("en_low", 4'hF, 7'h7F, 1'b0);
    end
    load   = 1'b1;
    bcd_in = 16'h0042;
    step();
    check("idle_load2", 4'hF, 7'h7F, 1'b0);
    en = 1'b1;
    step();
    check("reenable", 4'hF, 7'h7F, 1'b0);

    // Scenario 6: leading zeros (dark only when LZ_BLANK_EN is defined)
    run_frame(7'h24, 7'h19, 7'h40, 7'h40, DARK_0042, 1'b1, 16'h0000);
    run_frame(7'h40, 7'h40, 7'h40, 7'h40, DARK_0000, 1'b0, 16'h0);

    // Scenario 5b: asynchronous reset in the middle of a lit slot
    run_slot(0, 7'h40, 1'b0, 1'b0, 16'h0, 5);
    rst_n = 1'b0;
    #2;
    check("async_reset", 4'hF, 7'h7F, 1'b0);
    en = 1'b0;
    #10;
    rst_n = 1'b1;
    step();
    check("post_reset", 4'hF, 7'h7F, 1'b0);
    en = 1'b1;
    step();
    check("post_reset_en", 4'hF, 7'h7F, 1'b0);
    run_frame(7'h40, 7'h40, 7'h40, 7'h40, DARK_0000, 1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexing scheduler for the 4-digit, 0–9999 seven-segment display.
- Shares one segment bus between four digit anodes.
- Each digit gets a fixed time slot, with a dead-time blank at the start of every slot to prevent ghosting.
- Double-buffers the BCD value so a new count takes effect only at a frame boundary.

Parameters:
- SCAN_DIV, 131072: clk cycles per digit slot; legal range is 4 or more.
- BLANK_CYC, 16: blanked cycles at the start of each slot; legal range is 1 to SCAN_DIV-2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- en  in  1  scan enable.
- load  in  1  one-cycle pulse; samples bcd_in.
- bcd_in  in  16  digits d3..d0, 4 bits each; d0 = bits [3:0], least significant.
- an  out  4  anode enables, active-low; an[i] drives digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  out  1  one-cycle pulse at the end of the digit-3 slot.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset state:
  - an=4'hF, seg=7'h7F, frame_done=0.
  - Prescaler pcnt=0, digit index idx=0.
  - pending=0, display=0, state=IDLE.
- Output timing: all outputs are registered; pins reflect state/pcnt/idx with 1-cycle latency.
- Prescaler pcnt: counts 0..SCAN_DIV-1 while en=1, then wraps to 0.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: pcnt held at 0, idx=0.
    - en=1 → BLANK at pcnt=0, idx=0; this is a frame boundary.
  - BLANK: an=4'hF, seg=7'h7F.
    - At pcnt==BLANK_CYC-1 → SHOW.
  - SHOW: an[idx]=0 (all others 1), seg = decode(display digit idx).
    - At pcnt==SCAN_DIV-1 → BLANK, idx = (idx+1) mod 4.
    - Wrap 3→0 is a frame boundary.
- frame_done: pulses 1 in the cycle after the last SHOW cycle of idx=3; never pulses while en=0.
- Decode table (active-low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Codes 10–15 display '-' = 7'h3F.
- Buffering:
  - load=1 → pending <= bcd_in.
  - At each frame boundary: display <= (load ? bcd_in : pending).
  - Simultaneous load and boundary: bcd_in goes straight to display.
  - Multiple loads within one frame: the last one wins.
- en deasserted in any state: next cycle state=IDLE, pcnt=0, idx=0, outputs blanked, frame_done=0.
  - pending is unaffected; load is still accepted while in IDLE.
- Reset mid-slot: all registers return to reset values immediately (asynchronous); no partial frame resumes.

Optional Feature:
- Macro: LZ_BLANK_EN.
- Defined (leading-zero blanking):
  - For i=3..1, digit i is blanked when display digit i and all higher digits equal 0.
  - In that case its SHOW slot keeps an=4'hF, seg=7'h7F.
  - Slot timing, idx sequencing and frame_done are unchanged.
  - Digit 0 is always shown.
- Undefined: all four digits are always shown, zeros included.

Test Plan:
- Params SCAN_DIV=8, BLANK_CYC=2 for all scenarios.
- Scenario 1 (reset/idle): rst_n=0, then release with en=0 → an=4'hF, seg=7'h7F, frame_done=0 held for 50 cycles.
- Scenario 2 (scan sequence): load bcd_in=16'h1234, then en=1.
  - Per 8-cycle slot: 2 cycles blank, then 6 cycles with an=4'hE/seg=7'h19, then 4'hD/7'h30, 4'hB/7'h24, 4'h7/7'h79.
  - frame_done pulses once every 32 cycles.
- Scenario 3 (double buffering): mid-frame load 16'h9876 → current frame still shows 1234; next frame shows 9876. Load coinciding with a frame boundary takes effect in that same frame.
- Scenario 4 (invalid BCD): load 16'hFA05 → digit 3 and digit 2 show 7'h3F, digit 1 shows 7'h40, digit 0 shows 7'h12.
- Scenario 5 (en drop and async reset): drop en during the idx=2 SHOW slot → 1 cycle later blank, and restart from idx=0 BLANK on re-enable. Assert rst_n low mid-SHOW → an=4'hF immediately, without waiting for a clk edge.
- Scenario 6 (LZ_BLANK_EN): load 16'h0042 → digits 3 and 2 stay dark (an=4'hF during their slots); 4 and 2 are displayed. Load 16'h0000 → only digit 0 shows 7'h40.
